// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared constants and types for the LEGv8 pipeline: default datapath widths,
// the PC increment, the NOP encoding used for IF/ID bubbles, and pc_t/instr_t.
// No ports.
// -----------------------------------------------------------------------------
package legv8_pkg;

    localparam int DEF_PC_WIDTH    = 64;
    localparam int DEF_INSTR_WIDTH = 32;

    typedef logic [DEF_PC_WIDTH-1:0]    pc_t;
    typedef logic [DEF_INSTR_WIDTH-1:0] instr_t;

    localparam pc_t    PC_INC    = pc_t'(4);
    localparam instr_t NOP_INSTR = '0;

endpackage : legv8_pkg

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's control inputs, its instruction-memory port and
// its IF/ID outputs.
//   master : the fetch stage (drives imem_addr and the IF/ID fields)
//   slave  : hazard unit, branch resolution, instruction memory and decode
// Signals:
//   PCWrite, IF_ID_Write        stall controls from the hazard unit
//   branch_taken, branch_target redirect request and its address
//   imem_addr, imem_instr       combinational instruction-memory read
//   IF_ID_PC, IF_ID_Instr, IF_ID_Valid  contents of the IF/ID register
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int PC_WIDTH    = legv8_pkg::DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = legv8_pkg::DEF_INSTR_WIDTH
);
    logic                   PCWrite;
    logic                   IF_ID_Write;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic [PC_WIDTH-1:0]    IF_ID_PC;
    logic [INSTR_WIDTH-1:0] IF_ID_Instr;
    logic                   IF_ID_Valid;

    modport master (
        input  PCWrite, IF_ID_Write, branch_taken, branch_target, imem_instr,
        output imem_addr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid
    );

    modport slave (
        output PCWrite, IF_ID_Write, branch_taken, branch_target, imem_instr,
        input  imem_addr, IF_ID_PC, IF_ID_Instr, IF_ID_Valid
    );
endinterface : fetch_stage_if

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter flop. Per rising edge: redirect to the word-aligned target,
// else advance by PC_INC (wrapping modulo 2^PC_WIDTH), else hold.
// Ports:
//   clk, reset (async, active-high)
//   redirect   load the target this edge (highest priority)
//   advance    step to the next sequential instruction
//   target     redirect address; its two low bits are discarded
//   pc         current program counter
// -----------------------------------------------------------------------------
module pc_register
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic                advance,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of its inputs, regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {target[PC_WIDTH-1:2], 2'b00};
        end else if (advance) begin
            pc <= pc + PC_WIDTH'(PC_INC);
        end
    end

endmodule : pc_register

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// LEGv8 instruction-fetch stage: owns the PC and the IF/ID register, honours
// the PCWrite/IF_ID_Write stall controls, applies branch redirects with an
// IF/ID flush, and keeps saturating stall/flush event counters.
// Ports:
//   clk                  pipeline clock (rising edge)
//   reset                asynchronous, active-high reset
//   fif (master)         control inputs, imem port and IF/ID outputs
//   stall_count          cycles held by PCWrite=0 without a redirect
//   flush_count          number of redirects taken
// -----------------------------------------------------------------------------
module fetch_stage
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        fif,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [PC_WIDTH-1:0] pc;

    pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk      (clk),
        .reset    (reset),
        .redirect (fif.branch_taken),
        .advance  (fif.PCWrite),
        .target   (fif.branch_target),
        .pc       (pc)
    );

    // imem_addr is the PC flop itself: no input reaches it combinationally.
    assign fif.imem_addr = pc;

    // IF/ID register. A redirect flushes it to a bubble even if decode asked
    // to hold, because the held instruction is on the wrong path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fif.IF_ID_PC    <= '0;
            fif.IF_ID_Instr <= INSTR_WIDTH'(NOP_INSTR);
            fif.IF_ID_Valid <= 1'b0;
        end else if (fif.branch_taken) begin
            fif.IF_ID_PC    <= '0;
            fif.IF_ID_Instr <= INSTR_WIDTH'(NOP_INSTR);
            fif.IF_ID_Valid <= 1'b0;
        end else if (fif.IF_ID_Write) begin
            fif.IF_ID_PC    <= pc;
            fif.IF_ID_Instr <= fif.imem_instr;
            fif.IF_ID_Valid <= 1'b1;
        end
    end

    // Performance counters stick at all-ones so a long run never reads as a
    // small count after wrapping. A stall coinciding with a redirect is not
    // a stall: the redirect discards it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!fif.PCWrite && !fif.branch_taken && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
            if (fif.branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed stimulus for fetch_stage with a behavioural reference model that is
// compared against the DUT every falling edge, plus hand-computed literal
// expectations at key points. Counters are built 4 bits wide so saturation is
// reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import legv8_pkg::*;

    localparam int PW      = 64;
    localparam int IW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;

    int nVec = 0;
    int nErr = 0;

    fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) fif ();

    fetch_stage #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .RESET_PC    ('0),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fif         (fif),
        .stall_count (stallCount),
        .flush_count (flushCount)
    );

    always #5 clk = ~clk;

    // Instruction memory: a distinct, never-zero word for every address.
    function automatic logic [IW-1:0] instrOf(input logic [PW-1:0] a);
        return 32'hD000_0000 | {4'h0, a[27:0]};
    endfunction

    assign fif.imem_instr = instrOf(fif.imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PW-1:0] mPc      = '0;
    logic [PW-1:0] mIfPc    = '0;
    logic [IW-1:0] mIfInstr = '0;
    logic          mIfValid = 1'b0;
    int            mStall   = 0;
    int            mFlush   = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPc      <= '0;
            mIfPc    <= '0;
            mIfInstr <= '0;
            mIfValid <= 1'b0;
            mStall   <= 0;
            mFlush   <= 0;
        end else if (fif.branch_taken) begin
            mPc      <= fif.branch_target - (fif.branch_target % 4);
            mIfPc    <= '0;
            mIfInstr <= '0;
            mIfValid <= 1'b0;
            mFlush   <= (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
        end else begin
            if (fif.PCWrite) mPc <= mPc + 4;
            else             mStall <= (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
            if (fif.IF_ID_Write) begin
                mIfPc    <= mPc;
                mIfInstr <= instrOf(mPc);
                mIfValid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("imem_addr",   fif.imem_addr,          mPc);
        check("IF_ID_PC",    fif.IF_ID_PC,           mIfPc);
        check("IF_ID_Instr", 64'(fif.IF_ID_Instr),   64'(mIfInstr));
        check("IF_ID_Valid", 64'(fif.IF_ID_Valid),   64'(mIfValid));
        check("stall_count", 64'(stallCount),        64'(mStall));
        check("flush_count", 64'(flushCount),        64'(mFlush));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic pw, input logic iw, input logic bt, input logic [PW-1:0] tgt);
        fif.PCWrite       = pw;
        fif.IF_ID_Write   = iw;
        fif.branch_taken  = bt;
        fif.branch_target = tgt;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, '0);
        #1 reset = 1'b1;
        #1;
        check("lit_reset_addr",  fif.imem_addr, 64'h0);
        check("lit_reset_valid", 64'(fif.IF_ID_Valid), 64'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Sequential fetch from RESET_PC.
        check("lit_seq_addr0", fif.imem_addr, 64'h0);
        step();
        check("lit_seq_addr1", fif.imem_addr, 64'h4);
        check("lit_seq_ifpc1", fif.IF_ID_PC, 64'h0);
        check("lit_seq_vld1",  64'(fif.IF_ID_Valid), 64'h1);
        step();
        check("lit_seq_addr2", fif.imem_addr, 64'h8);
        check("lit_seq_ifpc2", fif.IF_ID_PC, 64'h4);

        // Two-cycle stall at PC=8.
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        step();
        check("lit_stall_addr",  fif.imem_addr, 64'h8);
        check("lit_stall_ifpc",  fif.IF_ID_PC, 64'h4);
        check("lit_stall_instr", 64'(fif.IF_ID_Instr), 64'hD000_0004);
        check("lit_stall_cnt",   64'(stallCount), 64'd2);
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        check("lit_resume_addr", fif.imem_addr, 64'hC);
        check("lit_resume_ifpc", fif.IF_ID_PC, 64'h8);
        step();

        // Redirect at PC=16 to unaligned 0x103.
        drive(1'b1, 1'b1, 1'b1, 64'h103);
        step();
        check("lit_br_addr",  fif.imem_addr, 64'h100);
        check("lit_br_vld",   64'(fif.IF_ID_Valid), 64'h0);
        check("lit_br_instr", 64'(fif.IF_ID_Instr), 64'h0);
        check("lit_br_flush", 64'(flushCount), 64'd1);
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        check("lit_br_ifpc",   fif.IF_ID_PC, 64'h100);
        check("lit_br_tinstr", 64'(fif.IF_ID_Instr), 64'hD000_0100);

        // Redirect and stall together: the redirect wins.
        drive(1'b0, 1'b0, 1'b1, 64'h200);
        step();
        check("lit_brst_addr",  fif.imem_addr, 64'h200);
        check("lit_brst_stall", 64'(stallCount), 64'd2);
        check("lit_brst_flush", 64'(flushCount), 64'd2);

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("lit_wrap_top", fif.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, '0);
        step();
        check("lit_wrap_addr", fif.imem_addr, 64'h0);
        check("lit_wrap_ifpc", fif.IF_ID_PC, 64'hFFFF_FFFF_FFFF_FFFC);

        // PCWrite and IF_ID_Write honoured independently.
        drive(1'b1, 1'b0, 1'b0, '0);
        step();
        check("lit_indep1_addr", fif.imem_addr, 64'h4);
        check("lit_indep1_ifpc", fif.IF_ID_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        check("lit_indep2_addr", fif.imem_addr, 64'h4);
        check("lit_indep2_ifpc", fif.IF_ID_PC, 64'h4);

        // Saturation of both counters.
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (15) step();
        check("lit_stall_sat", 64'(stallCount), 64'(CNT_MAX));
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, 1'b1, 64'(i * 8));
            step();
        end
        check("lit_flush_sat", 64'(flushCount), 64'(CNT_MAX));

        // Asynchronous reset in the middle of a stall.
        drive(1'b0, 1'b0, 1'b0, '0);
        step();
        reset = 1'b1;
        #1;
        check("lit_arst_addr",  fif.imem_addr, 64'h0);
        check("lit_arst_vld",   64'(fif.IF_ID_Valid), 64'h0);
        check("lit_arst_stall", 64'(stallCount), 64'h0);
        check("lit_arst_flush", 64'(flushCount), 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, '0);
        check("lit_post_addr", fif.imem_addr, 64'h0);
        step();
        check("lit_post_ifpc",  fif.IF_ID_PC, 64'h0);
        check("lit_post_instr", 64'(fif.IF_ID_Instr), 64'hD000_0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the LEGv8 five-stage pipeline: owns the program counter and the IF/ID pipeline register. Drives the instruction-memory address, latches the fetched instruction into IF/ID, and obeys the `PCWrite`/`IF_ID_Write` stall controls from the hazard detection unit. Applies branch redirects and IF/ID flushes from the branch-resolution logic, and keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- `PC_WIDTH`, 64, PC and branch-target width.
- `INSTR_WIDTH`, 32, instruction width.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `CNT_WIDTH`, 32, width of the performance counters.

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC (load-use stall).
- `IF_ID_Write`  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- `branch_taken`  in  1  redirect request (PCSrc) from branch resolution.
- `branch_target`  in  PC_WIDTH  redirect address; valid when `branch_taken`=1.
- `imem_addr`  out  PC_WIDTH  current PC, to instruction memory (combinational read).
- `imem_instr`  in  INSTR_WIDTH  instruction at `imem_addr`, same cycle.
- `IF_ID_PC`  out  PC_WIDTH  PC of the instruction held in IF/ID.
- `IF_ID_Instr`  out  INSTR_WIDTH  instruction held in IF/ID.
- `IF_ID_Valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `stall_count`  out  CNT_WIDTH  cycles stalled by `PCWrite`=0.
- `flush_count`  out  CNT_WIDTH  number of redirects taken.

## Operation
- Reset values: PC = `RESET_PC`, `IF_ID_PC` = 0, `IF_ID_Instr` = 0, `IF_ID_Valid` = 0, both counters = 0.
- `imem_addr` always equals the PC register. The block adds no combinational path from any input to `imem_addr`.
- PC update priority (per edge):
  1. `branch_taken`=1: PC <= {`branch_target`[PC_WIDTH-1:2], 2'b00}.
  2. Else `PCWrite`=1: PC <= PC + 4, modulo 2^PC_WIDTH. PC = 2^64-4 wraps to 0.
  3. Else PC holds.
- IF/ID update priority (per edge):
  1. `branch_taken`=1: flush. `IF_ID_Instr` <= 0, `IF_ID_PC` <= 0, `IF_ID_Valid` <= 0.
  2. Else `IF_ID_Write`=1: load `imem_instr` and the current PC, and set `IF_ID_Valid` <= 1.
  3. Else hold all three fields.
- Simultaneous redirect and stall: the redirect wins. PC takes the target, IF/ID is flushed, and the stall is discarded.
- `stall_count` increments when `PCWrite`=0 and `branch_taken`=0. `flush_count` increments when `branch_taken`=1. Both saturate at all-ones and never wrap.
- `PCWrite` and `IF_ID_Write` differing (not produced by the hazard unit) are still honoured independently.
- Flushing stages beyond IF/ID is not this block's job.

## Timing
- Fetch latency: the instruction at PC presented in cycle N appears on the IF/ID outputs after edge N+1.
- Redirect: `branch_taken` sampled at edge N. `imem_addr` equals the target after edge N. The first target instruction is in IF/ID after edge N+1, and IF/ID is a bubble for the cycle in between.
- Stall: `PCWrite`=`IF_ID_Write`=0 for k cycles freezes PC and IF/ID for exactly k edges. Fetch resumes at the same PC with no instruction lost or duplicated.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The first fetch after deassertion is at `RESET_PC`.

## Structure
- Shared package `legv8_pkg`: `PC_INC` = 4, `NOP_INSTR` = 0, `PC_WIDTH`/`INSTR_WIDTH` defaults, and a `pc_t` typedef.
- One sub-module, `pc_register`: the PC flop with redirect/advance/hold priority and async reset.
- The IF/ID register and the counters live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0, no stalls, 4 cycles: `imem_addr` = 0, 4, 8, 12. `IF_ID_PC` lags by one cycle, and `IF_ID_Valid` = 1 from the second edge.
- `PCWrite`=`IF_ID_Write`=0 for 2 cycles at PC=8: PC holds at 8 and IF/ID holds the PC=4 instruction. `stall_count`=2, then fetch resumes at 12.
- `branch_taken`=1, target 0x103 at PC=16: PC becomes 0x100 and IF/ID becomes a bubble (`Valid`=0, `Instr`=0). `flush_count`=1, and the instruction at 0x100 is in IF/ID one edge later.
- `branch_taken`=1 with `PCWrite`=0 in the same cycle: PC = target and IF/ID is flushed. `stall_count` is unchanged and `flush_count` increments.
- PC=64'hFFFF_FFFF_FFFF_FFFC with `PCWrite`=1: next PC = 0.
- Assert `reset` between clock edges during a stall: outputs go to reset values immediately, before the next edge.
- Force `stall_count` to all-ones, then stall once more: the counter stays at all-ones.
